// File: rtl/reu_pkg.sv
// reu_pkg: transfer-type encodings, engine states, default widths and first-state helper for the REU DMA engine
package reu_pkg;
  localparam int RAW_DEF = 24;
  localparam int CAW_DEF = 16;
  localparam int LW_DEF = 16;
  localparam logic [1:0] XFER_STASH = 2'b00;
  localparam logic [1:0] XFER_FETCH = 2'b01;
  localparam logic [1:0] XFER_SWAP = 2'b10;
  localparam logic [1:0] XFER_VERIFY = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_C64RD, ST_C64WR, ST_RAMRD, ST_RAMWR, ST_NEXT, ST_FIN} state_t;
  function automatic state_t first_state(input logic [1:0] t);
    return t == XFER_STASH ? ST_C64RD : ST_RAMRD;
  endfunction
endpackage

// File: rtl/reu_addr_ctr.sv
// reu_addr_ctr: loadable up/down counter with hold and natural wrap (clk, rst, load/load_val, step, hold -> q)
module reu_addr_ctr #(
  parameter int W = 16,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         hold,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = load ? load_val : (step && !hold) ? (DOWN ? q_q - W'(1) : q_q + W'(1)) : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/reu_dma_engine.sv
// reu_dma_engine: REU DMA sequencer moving bytes between C64 bus (BA/DMA/CA/C64WE) and SDRAM (RAMReq/RAMAck) for stash/fetch/swap/verify, with final CA/REUA/LenOut write-back
module reu_dma_engine import reu_pkg::*; #(
  parameter int RAW = RAW_DEF,
  parameter int CAW = CAW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic           PHI2,
  input  logic           RESET,
  input  logic           BA,
  input  logic           Execute,
  input  logic [1:0]     XferType,
  input  logic           CAHold,
  input  logic           REUAHold,
  input  logic [CAW-1:0] CAStart,
  input  logic [RAW-1:0] REUAStart,
  input  logic [LW-1:0]  LenStart,
  output logic           RAMReq,
  output logic           RAMWr,
  output logic [RAW-1:0] RAMA,
  output logic [7:0]     RAMWD,
  input  logic [7:0]     RAMRD,
  input  logic           RAMAck,
  output logic           DMA,
  output logic [CAW-1:0] CA,
  output logic           C64WE,
  output logic [7:0]     C64DOut,
  input  logic [7:0]     C64DIn,
  output logic           Busy,
  output logic           Done,
  output logic           XferEnd,
  output logic           VerifyErr,
  output logic [RAW-1:0] REUA,
  output logic [LW-1:0]  LenOut
);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic ch_q, ch_d, rh_q, rh_d, err_q, err_d;
  logic ramreq_q, ramreq_d, ramwr_q, ramwr_d;
  logic busy_q, busy_d, dma_q, dma_d, done_q, done_d, xend_q, xend_d, verr_q, verr_d;
  logic [7:0] tmp_q, tmp_d, ramwd_q, ramwd_d;
  logic start, step, last;
  assign start = state_q == ST_IDLE && Execute;
  assign step = state_q == ST_NEXT;
  assign last = LenOut == LW'(1);
  reu_addr_ctr #(.W(CAW)) u_ca (.clk(PHI2), .rst(RESET), .load(start), .load_val(CAStart), .step(step), .hold(ch_q), .q(CA));
  reu_addr_ctr #(.W(RAW)) u_reua (.clk(PHI2), .rst(RESET), .load(start), .load_val(REUAStart), .step(step), .hold(rh_q), .q(REUA));
  reu_addr_ctr #(.W(LW), .DOWN(1'b1)) u_len (.clk(PHI2), .rst(RESET), .load(start), .load_val(LenStart), .step(step), .hold(last), .q(LenOut));
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    ch_d = ch_q;
    rh_d = rh_q;
    err_d = err_q;
    tmp_d = tmp_q;
    ramreq_d = ramreq_q;
    ramwr_d = ramwr_q;
    ramwd_d = ramwd_q;
    busy_d = busy_q;
    dma_d = dma_q;
    done_d = 1'b0;
    xend_d = xend_q;
    verr_d = verr_q;
    case (state_q)
      ST_IDLE: if (Execute) begin
        state_d = first_state(XferType);
        mode_d = XferType;
        ch_d = CAHold;
        rh_d = REUAHold;
        err_d = 1'b0;
        xend_d = 1'b0;
        verr_d = 1'b0;
        busy_d = 1'b1;
        dma_d = 1'b1;
        ramreq_d = XferType != XFER_STASH;
        ramwr_d = 1'b0;
      end
      ST_RAMRD: if (RAMAck) begin
        ramreq_d = 1'b0;
        tmp_d = RAMRD;
        state_d = mode_q == XFER_FETCH ? ST_C64WR : ST_C64RD;
      end
      ST_C64RD: if (BA) begin
        state_d = mode_q == XFER_VERIFY ? ST_NEXT : ST_RAMWR;
        err_d = mode_q == XFER_VERIFY && C64DIn != tmp_q;
        verr_d = mode_q == XFER_VERIFY && C64DIn != tmp_q;
        ramreq_d = mode_q != XFER_VERIFY;
        ramwr_d = mode_q != XFER_VERIFY;
        ramwd_d = C64DIn;
      end
      ST_RAMWR: if (RAMAck) begin
        ramreq_d = 1'b0;
        ramwr_d = 1'b0;
        state_d = mode_q == XFER_SWAP ? ST_C64WR : ST_NEXT;
      end
      ST_C64WR: state_d = BA ? ST_NEXT : ST_C64WR;
      ST_NEXT: if (last || err_q) begin
        state_d = ST_FIN;
        xend_d = last;
        busy_d = 1'b0;
        dma_d = 1'b0;
        done_d = 1'b1;
      end else begin
        state_d = first_state(mode_q);
        ramreq_d = mode_q != XFER_STASH;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge PHI2) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      mode_q <= '0;
      ch_q <= 1'b0;
      rh_q <= 1'b0;
      err_q <= 1'b0;
      tmp_q <= '0;
      ramreq_q <= 1'b0;
      ramwr_q <= 1'b0;
      ramwd_q <= '0;
      busy_q <= 1'b0;
      dma_q <= 1'b0;
      done_q <= 1'b0;
      xend_q <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      ch_q <= ch_d;
      rh_q <= rh_d;
      err_q <= err_d;
      tmp_q <= tmp_d;
      ramreq_q <= ramreq_d;
      ramwr_q <= ramwr_d;
      ramwd_q <= ramwd_d;
      busy_q <= busy_d;
      dma_q <= dma_d;
      done_q <= done_d;
      xend_q <= xend_d;
      verr_q <= verr_d;
    end
  end
  assign RAMReq = ramreq_q;
  assign RAMWr = ramwr_q;
  assign RAMA = REUA;
  assign RAMWD = ramwd_q;
  assign DMA = dma_q;
  assign C64WE = state_q == ST_C64WR && BA;
  assign C64DOut = tmp_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign XferEnd = xend_q;
  assign VerifyErr = verr_q;
endmodule

// File: tb/tb_reu_dma_engine.sv
// tb_reu_dma_engine: directed and random transfers against C64/SDRAM bus models and a byte-level reference
module tb_reu_dma_engine;
  logic PHI2 = 0, RESET = 1, BA = 0, Execute = 0;
  logic [1:0] XferType = 0;
  logic CAHold = 0, REUAHold = 0;
  logic [15:0] CAStart = 0;
  logic [23:0] REUAStart = 0;
  logic [3:0] LenStart = 0;
  logic RAMReq, RAMWr, RAMAck = 0, DMA, C64WE, Busy, Done, XferEnd, VerifyErr;
  logic [23:0] RAMA, REUA;
  logic [7:0] RAMWD, RAMRD = 0, C64DOut, C64DIn = 0;
  logic [15:0] CA;
  logic [3:0] LenOut;
  reu_dma_engine #(.LW(4)) dut (
    .PHI2(PHI2), .RESET(RESET), .BA(BA), .Execute(Execute), .XferType(XferType),
    .CAHold(CAHold), .REUAHold(REUAHold), .CAStart(CAStart), .REUAStart(REUAStart),
    .LenStart(LenStart), .RAMReq(RAMReq), .RAMWr(RAMWr), .RAMA(RAMA), .RAMWD(RAMWD),
    .RAMRD(RAMRD), .RAMAck(RAMAck), .DMA(DMA), .CA(CA), .C64WE(C64WE), .C64DOut(C64DOut),
    .C64DIn(C64DIn), .Busy(Busy), .Done(Done), .XferEnd(XferEnd), .VerifyErr(VerifyErr),
    .REUA(REUA), .LenOut(LenOut)
  );
  always #5 PHI2 = ~PHI2;
  int errors = 0, checks = 0;
  int ba_mode = 0, lat = 1, req_cnt = 0, cyc = 0;
  logic [7:0] c64 [65536];
  logic [7:0] exp_c64 [65536];
  logic [7:0] ram [int];
  logic [7:0] exp_ram [int];
  int ev_code[$], ev_addr[$], ev_cyc[$], xc[$], xa[$];
  logic [23:0] hold_a;
  logic [8:0] hold_wd;
  int e_ca, e_ra, e_len, e_xend, e_verr, e_bytes;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] dflt(input int a);
    return 8'(a ^ (a >> 8) ^ 'h3C);
  endfunction
  function automatic logic [7:0] ram_rd(input int a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] exp_rd(input int a);
    return exp_ram.exists(a) ? exp_ram[a] : dflt(a);
  endfunction
  // bus models: SDRAM acks after lat cycles of request, C64 memory answers reads and takes strobed writes
  always begin
    @(negedge PHI2);
    cyc++;
    BA = ba_mode == 0 ? 1'b1 : ba_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
    C64DIn = c64[CA];
    RAMAck = 0;
    if (RAMReq) begin
      if (req_cnt == 0) begin
        hold_a = RAMA;
        hold_wd = {RAMWr, RAMWD};
      end else begin
        check("ram_addr_stable", RAMA, hold_a);
        check("ram_wr_data_stable", hold_wd, {RAMWr, RAMWD});
      end
      req_cnt++;
      if (req_cnt >= lat) begin
        RAMAck = 1;
        req_cnt = 0;
        if (RAMWr) ram[RAMA] = RAMWD;
        else RAMRD = ram_rd(RAMA);
        ev_code.push_back(RAMWr ? 2 : 1);
        ev_addr.push_back(RAMA);
        ev_cyc.push_back(cyc);
      end
    end else req_cnt = 0;
    #1;
    if (C64WE) begin
      check("c64we_needs_ba", BA, 1);
      c64[CA] = C64DOut;
      ev_code.push_back(3);
      ev_addr.push_back(CA);
      ev_cyc.push_back(cyc);
    end
  end
  // byte-at-a-time reference of a whole transfer on snapshot memories
  task automatic ref_run(input int mode, input int ca, input int ra, input int len, input int ch, input int rh);
    int n;
    logic [7:0] cb, rb;
    bit mis;
    n = len == 0 ? 16 : len;
    exp_c64 = c64;
    exp_ram = ram;
    e_xend = 0;
    e_verr = 0;
    e_bytes = 0;
    e_len = 0;
    for (int i = 0; i < n; i++) begin
      cb = exp_c64[ca];
      rb = exp_rd(ra);
      mis = 0;
      if (mode == 0) exp_ram[ra] = cb;
      if (mode == 1) exp_c64[ca] = rb;
      if (mode == 2) begin exp_ram[ra] = cb; exp_c64[ca] = rb; end
      if (mode == 3) mis = cb != rb;
      e_bytes++;
      if (!ch) ca = (ca + 1) & 'hFFFF;
      if (!rh) ra = (ra + 1) & 'hFFFFFF;
      if (mis || i == n - 1) begin
        e_xend = i == n - 1;
        e_verr = mis;
        e_len = e_xend ? 1 : n - i - 1;
        break;
      end
    end
    e_ca = ca;
    e_ra = ra;
  endtask
  task automatic check_ev(input string nm);
    check({nm, " ev_count"}, ev_code.size(), xc.size());
    for (int i = 0; i < xc.size() && i < ev_code.size(); i++) begin
      check({nm, " ev_kind"}, ev_code[i], xc[i]);
      check({nm, " ev_addr"}, ev_addr[i], xa[i]);
    end
  endtask
  task automatic run(input string nm, input int mode, input int ca, input int ra, input int len,
                     input int ch, input int rh, input int bm, input int l);
    int k, cnt, nr, nw, nc, per;
    bit got;
    ba_mode = bm;
    lat = l;
    ref_run(mode, ca, ra, len, ch, rh);
    @(negedge PHI2);
    ev_code.delete(); ev_addr.delete(); ev_cyc.delete();
    XferType = 2'(mode); CAStart = 16'(ca); REUAStart = 24'(ra); LenStart = 4'(len);
    CAHold = ch[0]; REUAHold = rh[0]; Execute = 1;
    @(negedge PHI2);
    Execute = 0;
    k = 1;
    got = 0;
    while (k <= 3000) begin
      if (Done) begin got = 1; break; end
      @(negedge PHI2);
      k++;
    end
    check({nm, " done_seen"}, got, 1);
    if (!got) begin RESET = 1; @(negedge PHI2); RESET = 0; return; end
    per = mode == 2 ? 3 + 2 * l : 2 + l;
    if (bm == 0) check({nm, " cycles"}, k, per * e_bytes + 1);
    check({nm, " CA"}, CA, e_ca);
    check({nm, " REUA"}, REUA, e_ra);
    check({nm, " LenOut"}, LenOut, e_len);
    check({nm, " XferEnd"}, XferEnd, e_xend);
    check({nm, " VerifyErr"}, VerifyErr, e_verr);
    check({nm, " busy_dma_at_done"}, {Busy, DMA}, 0);
    cnt = 0;
    for (int i = 0; i < 65536; i++) if (c64[i] !== exp_c64[i]) cnt++;
    check({nm, " c64_mem_diffs"}, cnt, 0);
    cnt = 0;
    foreach (exp_ram[a]) if (ram_rd(a) !== exp_rd(a)) cnt++;
    foreach (ram[a]) if (ram_rd(a) !== exp_rd(a)) cnt++;
    check({nm, " ram_diffs"}, cnt, 0);
    nr = 0; nw = 0; nc = 0;
    foreach (ev_code[i]) begin
      nr += ev_code[i] == 1 ? 1 : 0;
      nw += ev_code[i] == 2 ? 1 : 0;
      nc += ev_code[i] == 3 ? 1 : 0;
    end
    check({nm, " ram_reads"}, nr, mode != 0 ? e_bytes : 0);
    check({nm, " ram_writes"}, nw, (mode == 0 || mode == 2) ? e_bytes : 0);
    check({nm, " c64_writes"}, nc, (mode == 1 || mode == 2) ? e_bytes : 0);
    @(negedge PHI2);
    check({nm, " done_one_cycle"}, Done, 0);
  endtask
  initial begin
    int mode, ca, ra, len, ch, rh, n, c, r;
    for (int i = 0; i < 65536; i++) c64[i] = 8'($urandom);
    repeat (3) @(negedge PHI2);
    check("reset_flags", {RAMReq, RAMWr, DMA, C64WE, Busy, Done, XferEnd, VerifyErr}, 0);
    check("reset_CA", CA, 0);
    check("reset_REUA", REUA, 0);
    check("reset_LenOut", LenOut, 0);
    check("reset_data", {RAMWD, C64DOut}, 0);
    RESET = 0;
    run("stash", 0, 'h1000, 'h20, 3, 0, 0, 0, 1);
    xc = '{2, 2, 2}; xa = '{'h20, 'h21, 'h22};
    check_ev("stash");
    check("stash_CA_const", CA, 'h1003);
    check("stash_REUA_const", REUA, 'h23);
    check("stash_ram20", ram_rd('h20), c64['h1000]);
    run("fetch", 1, 'h2000, 'h400, 2, 0, 1, 0, 4);
    xc = '{1, 3, 1, 3}; xa = '{'h400, 'h2000, 'h400, 'h2001};
    check_ev("fetch");
    c64['h3000] = 8'h55;
    ram['h500] = 8'hAA;
    run("swap", 2, 'h3000, 'h500, 1, 0, 0, 0, 1);
    xc = '{1, 2, 3}; xa = '{'h500, 'h500, 'h3000};
    check_ev("swap");
    check("swap_c64", c64['h3000], 8'hAA);
    check("swap_ram", ram_rd('h500), 8'h55);
    check("swap_rd_to_wr_gap", ev_cyc[1] - ev_cyc[0], 2);
    check("swap_wr_to_c64wr_gap", ev_cyc[2] - ev_cyc[1], 1);
    for (int i = 0; i < 4; i++) ram['h600 + i] = c64['h4000 + i];
    ram['h601] = ram['h601] ^ 8'hFF;
    run("verify", 3, 'h4000, 'h600, 4, 0, 0, 0, 1);
    xc = '{1, 1}; xa = '{'h600, 'h601};
    check_ev("verify");
    check("verify_CA_const", CA, 'h4002);
    check("verify_Len_const", LenOut, 2);
    check("verify_flags", {XferEnd, VerifyErr}, 2'b01);
    ba_mode = 2;
    @(negedge PHI2);
    ev_code.delete(); ev_addr.delete(); ev_cyc.delete();
    XferType = 0; CAStart = 'h5000; REUAStart = 'h700; LenStart = 3; CAHold = 0; REUAHold = 0; Execute = 1;
    @(negedge PHI2);
    Execute = 0;
    for (int i = 0; i < 5; i++) begin
      check("ba_stall_dma_busy", {DMA, Busy}, 2'b11);
      check("ba_stall_no_strobe", {C64WE, RAMReq}, 0);
      @(negedge PHI2);
    end
    RESET = 1;
    @(negedge PHI2);
    check("abort_outputs", {DMA, Busy, Done, RAMReq}, 0);
    RESET = 0;
    ba_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PHI2);
      check("abort_no_done", {Done, Busy}, 0);
    end
    check("abort_no_access", ev_code.size(), 0);
    run("wrap", 0, 'hFFFF, 'hFFFFFF, 0, 0, 0, 0, 1);
    check("wrap_CA_const", CA, 'h000F);
    check("wrap_REUA_const", REUA, 'h00000F);
    check("wrap_second_ram_addr", ev_addr[1], 0);
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 3);
      ca = $urandom_range(0, 1) ? 'hFFF0 + $urandom_range(0, 15) : $urandom_range(0, 'hFFFF);
      ra = $urandom_range(0, 1) ? 'hFFFFF0 + $urandom_range(0, 15) : $urandom_range(0, 'hFFFFFF);
      len = $urandom_range(0, 15);
      ch = $urandom_range(0, 3) == 0;
      rh = $urandom_range(0, 3) == 0;
      n = len == 0 ? 16 : len;
      if (mode == 3) begin
        c = ca; r = ra;
        for (int i = 0; i < n; i++) begin
          ram[r] = c64[c];
          if (!ch) c = (c + 1) & 'hFFFF;
          if (!rh) r = (r + 1) & 'hFFFFFF;
        end
        if ($urandom_range(0, 1)) begin
          r = rh ? ra : (ra + $urandom_range(0, n - 1)) & 'hFFFFFF;
          ram[r] = ram_rd(r) ^ 8'h01;
        end
      end
      run("random", mode, ca, ra, len, ch, rh, $urandom_range(0, 1), $urandom_range(1, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
